// File: rtl/img_pkg.sv
// Shared pixel types and helpers for the frame-buffer reader.
package img_pkg;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef enum logic {
    MODE_1X = 1'b0,
    MODE_2X = 1'b1
  } disp_mode_e;

  // Side-band travelling alongside the memory read.
  typedef struct packed {
    logic in_win;
    logic de;
    logic h_sync;
    logic v_sync;
  } sband_t;

  function automatic rgb444_t rgb565_to_444(input rgb565_t p);
    rgb444_t q;
    q.r = p.r[4:1];
    q.g = p.g[5:2];
    q.b = p.b[4:1];
    return q;
  endfunction

endpackage

// File: rtl/img_delay_line.sv
// Fixed-depth shift register, cleared by reset; output is the input DEPTH clocks later.
module img_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/img_reader_scaled.sv
// Frame-buffer reader: raster (x,y) -> address, read latency absorbed, RGB444 aligned
// with delayed DE/syncs (latency MEM_LAT+2). 1x and 2x pixel-doubled modes.
module img_reader_scaled
  import img_pkg::*;
#(
  parameter int          IMG_W   = 320,
  parameter int          IMG_H   = 240,
  parameter int          ADDR_W  = 17,
  parameter int          MEM_LAT = 1,
  parameter logic [11:0] BG_RGB  = 12'h000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              de_i,
  input  logic              h_sync_i,
  input  logic              v_sync_i,
  input  logic [9:0]        x_i,
  input  logic [9:0]        y_i,
  input  logic              mode_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              rd_en_o,
  input  logic [15:0]       data_i,
  output logic [3:0]        r_o,
  output logic [3:0]        g_o,
  output logic [3:0]        b_o,
  output logic              de_o,
  output logic              h_sync_o,
  output logic              v_sync_o
);

  disp_mode_e        mode_q;
  disp_mode_e        mode_eff;
  logic              frame_start;
  logic [9:0]        xs;
  logic [9:0]        ys;
  logic              in_win;
  logic [ADDR_W-1:0] addr_next;
  sband_t            sb_s0;
  sband_t            sb_dly;
  rgb444_t           pix;

  // Mode only switches on the first visible pixel so a frame never mixes scales.
  assign frame_start = de_i && (x_i == 10'd0) && (y_i == 10'd0);
  assign mode_eff    = frame_start ? disp_mode_e'(mode_i) : mode_q;

  assign xs = (mode_eff == MODE_2X) ? {1'b0, x_i[9:1]} : x_i;
  assign ys = (mode_eff == MODE_2X) ? {1'b0, y_i[9:1]} : y_i;

  assign in_win = de_i
               && ({22'd0, xs} < 32'(IMG_W))
               && ({22'd0, ys} < 32'(IMG_H));

  assign addr_next = ADDR_W'({22'd0, ys} * 32'(IMG_W) + {22'd0, xs});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q  <= MODE_1X;
      addr_o  <= '0;
      rd_en_o <= 1'b0;
      sb_s0   <= '0;
    end else begin
      mode_q  <= mode_eff;
      rd_en_o <= in_win;
      if (in_win) addr_o <= addr_next;
      sb_s0.in_win <= in_win;
      sb_s0.de     <= de_i;
      sb_s0.h_sync <= h_sync_i;
      sb_s0.v_sync <= v_sync_i;
    end
  end

  img_delay_line #(
    .WIDTH ($bits(sband_t)),
    .DEPTH (MEM_LAT)
  ) u_sband_dly (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (sb_s0),
    .q       (sb_dly)
  );

  assign pix = rgb565_to_444(rgb565_t'(data_i));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_o      <= '0;
      g_o      <= '0;
      b_o      <= '0;
      de_o     <= 1'b0;
      h_sync_o <= 1'b0;
      v_sync_o <= 1'b0;
    end else begin
      de_o     <= sb_dly.de;
      h_sync_o <= sb_dly.h_sync;
      v_sync_o <= sb_dly.v_sync;
      if (sb_dly.in_win) begin
        r_o <= pix.r;
        g_o <= pix.g;
        b_o <= pix.b;
      end else begin
        r_o <= BG_RGB[11:8];
        g_o <= BG_RGB[7:4];
        b_o <= BG_RGB[3:0];
      end
    end
  end

endmodule

// File: tb/tb_img_reader_scaled.sv
// Directed bench: MEM_LAT=1 and MEM_LAT=3 readers fed the same raster stream.
module tb_img_reader_scaled;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        de, hs, vs, mode;
  logic [9:0]  x, y;

  logic [16:0] addr1, addr3;
  logic        rd1, rd3;
  logic [15:0] d1, d3;
  logic [3:0]  r1, g1, b1, r3, g3, b3;
  logic        de1, hs1, vs1, de3, hs3, vs3;
  logic [15:0] m3a, m3b;

  always #5 clk = ~clk;

  img_reader_scaled #(.MEM_LAT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .de_i(de), .h_sync_i(hs), .v_sync_i(vs),
    .x_i(x), .y_i(y), .mode_i(mode), .addr_o(addr1), .rd_en_o(rd1), .data_i(d1),
    .r_o(r1), .g_o(g1), .b_o(b1), .de_o(de1), .h_sync_o(hs1), .v_sync_o(vs1)
  );

  img_reader_scaled #(.MEM_LAT(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .de_i(de), .h_sync_i(hs), .v_sync_i(vs),
    .x_i(x), .y_i(y), .mode_i(mode), .addr_o(addr3), .rd_en_o(rd3), .data_i(d3),
    .r_o(r3), .g_o(g3), .b_o(b3), .de_o(de3), .h_sync_o(hs3), .v_sync_o(vs3)
  );

  // Frame-buffer contents: address 645 holds 16'hF81F.
  function automatic logic [15:0] memf(input logic [16:0] a);
    return a[15:0] ^ 16'hFA9A;
  endfunction

  always @(posedge clk) d1 <= memf(addr1);
  always @(posedge clk) begin
    m3a <= memf(addr3);
    m3b <= m3a;
    d3  <= m3b;
  end

  typedef struct {
    logic        de, hs, vs, mode;
    logic [9:0]  x, y;
    logic        rd;
    logic [16:0] addr;
  } vec_t;

  vec_t vq[$];
  vec_t hist[256];
  int   c = 0;
  int   base = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void addv(input logic vde, vhs, vvs, vmd, input int vx, vy,
                               input logic vrd, input int vad);
    vec_t v;
    v.de = vde; v.hs = vhs; v.vs = vvs; v.mode = vmd;
    v.x = 10'(vx); v.y = 10'(vy); v.rd = vrd; v.addr = 17'(vad);
    vq.push_back(v);
  endfunction

  function automatic vec_t get(input int idx);
    vec_t z = '{default: '0};
    if (idx < base) return z;
    return hist[idx];
  endfunction

  function automatic logic [11:0] exp_rgb(input vec_t v);
    logic [15:0] d;
    d = memf(v.addr);
    return v.rd ? {d[15:12], d[10:7], d[4:1]} : 12'h000;
  endfunction

  task automatic check_outputs();
    vec_t a, p1, p3;
    a  = get(c - 1);
    p1 = get(c - 3);
    p3 = get(c - 5);
    chk($sformatf("c%0d addr1", c), 32'(addr1), 32'(a.addr));
    chk($sformatf("c%0d addr3", c), 32'(addr3), 32'(a.addr));
    chk($sformatf("c%0d rd1", c), 32'(rd1), 32'(a.rd));
    chk($sformatf("c%0d rd3", c), 32'(rd3), 32'(a.rd));
    chk($sformatf("c%0d de1", c), 32'(de1), 32'(p1.de));
    chk($sformatf("c%0d hs1", c), 32'(hs1), 32'(p1.hs));
    chk($sformatf("c%0d vs1", c), 32'(vs1), 32'(p1.vs));
    chk($sformatf("c%0d rgb1", c), 32'({r1, g1, b1}), 32'(exp_rgb(p1)));
    chk($sformatf("c%0d de3", c), 32'(de3), 32'(p3.de));
    chk($sformatf("c%0d hs3", c), 32'(hs3), 32'(p3.hs));
    chk($sformatf("c%0d vs3", c), 32'(vs3), 32'(p3.vs));
    chk($sformatf("c%0d rgb3", c), 32'({r3, g3, b3}), 32'(exp_rgb(p3)));
  endtask

  task automatic step(input vec_t v);
    @(negedge clk);
    check_outputs();
    de = v.de; hs = v.hs; vs = v.vs; mode = v.mode; x = v.x; y = v.y;
    hist[c] = v;
    c++;
  endtask

  // Reset asserted between edges must clear every output at once.
  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    de = 1'b1; hs = 1'b1; vs = 1'b1; mode = 1'b1; x = 10'd0; y = 10'd0;
    #1;
    chk("rst addr1", 32'(addr1), 32'd0);
    chk("rst addr3", 32'(addr3), 32'd0);
    chk("rst rd1", 32'(rd1), 32'd0);
    chk("rst rd3", 32'(rd3), 32'd0);
    chk("rst rgb1", 32'({r1, g1, b1}), 32'd0);
    chk("rst rgb3", 32'({r3, g3, b3}), 32'd0);
    chk("rst sync1", 32'({de1, hs1, vs1}), 32'd0);
    chk("rst sync3", 32'({de3, hs3, vs3}), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    de = 1'b0; hs = 1'b0; vs = 1'b0; mode = 1'b0; x = 10'd0; y = 10'd0;
    #2 reset_n = 1'b1;
    base = c;
  endtask

  int rst_at;

  initial begin
    reset_n = 1'b1;
    de = 1'b0; hs = 1'b0; vs = 1'b0; mode = 1'b0; x = 10'd0; y = 10'd0;

    //    de hs vs md   x    y   rd  addr
    addv(1, 0, 0, 0,   5,   2, 1,   645);
    addv(1, 1, 0, 0, 320,   0, 0,   645);
    addv(1, 0, 1, 0, 319, 239, 1, 76799);
    addv(0, 1, 0, 0,   0,   0, 0, 76799);
    addv(1, 0, 0, 0,   0,   0, 1,     0);
    addv(1, 1, 1, 1, 100,  50, 1, 16100);
    addv(1, 0, 0, 1, 400, 300, 0, 16100);
    addv(1, 0, 1, 1,   0,   0, 1,     0);
    addv(1, 1, 0, 0,   2,   0, 1,     1);
    addv(1, 0, 0, 0,   3,   0, 1,     1);
    addv(1, 0, 0, 0, 639, 479, 1, 76799);
    addv(1, 1, 0, 0, 640,   0, 0, 76799);
    addv(1, 0, 0, 0,   0, 480, 0, 76799);
    addv(1, 0, 1, 0, 1023, 1023, 0, 76799);
    addv(1, 0, 0, 0, 400, 300, 1, 48200);
    addv(0, 0, 1, 0,  10,  10, 0, 48200);
    addv(1, 0, 0, 0,   0,   0, 1,     0);
    addv(1, 0, 0, 0, 700,   5, 0,     0);
    addv(1, 0, 0, 0, 319,   0, 1,   319);
    addv(0, 1, 1, 0,   0,   0, 0,   319);
    rst_at = vq.size();
    addv(1, 0, 0, 1,   5,   2, 1,   645);
    addv(1, 1, 0, 0,   6,   2, 1,   646);
    addv(0, 0, 0, 0,   0,   0, 0,   646);
    addv(0, 0, 1, 0,   0,   0, 0,   646);
    addv(0, 1, 0, 0,   0,   0, 0,   646);
    addv(0, 0, 0, 0,   0,   0, 0,   646);
    addv(0, 0, 0, 0,   0,   0, 0,   646);

    do_reset();
    for (int i = 0; i < vq.size(); i++) begin
      if (i == rst_at) do_reset();
      step(vq[i]);
    end
    @(negedge clk);
    check_outputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
